// File: rtl/troco_pkg.sv
// troco_pkg: shared note values, error codes and FSM states for the change dispenser
package troco_pkg;
  localparam int N_NOTAS = 6;
  localparam logic [7:0] VALOR_NOTA [N_NOTAS] = '{8'd2, 8'd5, 8'd10, 8'd20, 8'd50, 8'd100};
  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_TROCO = 3'b100;
  typedef enum logic [2:0] {IDLE, SELECIONA, ENTREGA, PAUSA, FIM, ERRO} estado_t;
endpackage

// File: rtl/seletor_cedula.sv
// seletor_cedula: greedy pick of the largest stocked note not exceeding restante
module seletor_cedula
  import troco_pkg::*;
#(
  parameter int VALOR_W = 8
) (
  input  logic [VALOR_W-1:0] restante,
  input  logic [N_NOTAS-1:0] disponivel,
  output logic [VALOR_W-1:0] nota,
  output logic               valido
);
  always_comb begin
    nota = '0;
    valido = 1'b0;
    for (int i = 0; i < N_NOTAS; i++)
      if (disponivel[i] && VALOR_W'(VALOR_NOTA[i]) <= restante) begin
        nota = VALOR_W'(VALOR_NOTA[i]);
        valido = 1'b1;
      end
  end
endmodule

// File: rtl/dispensador_troco.sv
// dispensador_troco: pays out a change amount note by note through the hopper handshake
module dispensador_troco
  import troco_pkg::*;
#(
  parameter int VALOR_W = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [VALOR_W-1:0] valor_troco,
  input  logic [5:0]         disponivel,
  input  logic               nota_ack,
  input  logic               limpar_erro,
  output logic               libera,
  output logic [VALOR_W-1:0] nota_saida,
  output logic               ocupado,
  output logic               pronto,
  output logic [VALOR_W-1:0] restante,
  output logic [2:0]         erro_code
);
  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT_CYC - 1);
  estado_t state;
  logic [7:0] timer;
  logic [VALOR_W-1:0] nota;
  logic valido;
  seletor_cedula #(.VALOR_W(VALOR_W)) u_sel (
    .restante  (restante),
    .disponivel(disponivel),
    .nota      (nota),
    .valido    (valido)
  );
  assign ocupado = (state != IDLE) && (state != ERRO);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      libera <= 1'b0;
      nota_saida <= '0;
      pronto <= 1'b0;
      restante <= '0;
      erro_code <= ERR_NONE;
    end else begin
      pronto <= 1'b0;
      case (state)
        IDLE: if (iniciar) begin
          restante <= valor_troco;
          state <= SELECIONA;
        end
        SELECIONA: if (restante == '0) begin
          pronto <= 1'b1;
          state <= FIM;
        end else if (!valido) begin
          erro_code <= ERR_TROCO;
          state <= ERRO;
        end else begin
          nota_saida <= nota;
          libera <= 1'b1;
          timer <= '0;
          state <= ENTREGA;
        end
        ENTREGA: if (nota_ack) begin
          restante <= restante - nota_saida;
          libera <= 1'b0;
          nota_saida <= '0;
          state <= PAUSA;
        end else if (timer == TIMER_MAX) begin
          erro_code <= ERR_TIMEOUT;
          libera <= 1'b0;
          nota_saida <= '0;
          state <= ERRO;
        end else timer <= timer + 8'd1;
        PAUSA: state <= SELECIONA;
        FIM: state <= IDLE;
        ERRO: if (limpar_erro) begin
          erro_code <= ERR_NONE;
          restante <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dispensador_troco.sv
// tb_dispensador_troco: table-driven payout scenarios plus reset and ignored-start sequences
module tb_dispensador_troco;
  logic clk = 1'b0;
  logic reset, iniciar, nota_ack, limpar_erro;
  logic [7:0] valor_troco, nota_saida, restante;
  logic [5:0] disponivel;
  logic libera, ocupado, pronto;
  logic [2:0] erro_code;
  int checks = 0;
  int errors = 0;

  dispensador_troco dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .valor_troco(valor_troco),
    .disponivel(disponivel), .nota_ack(nota_ack), .limpar_erro(limpar_erro),
    .libera(libera), .nota_saida(nota_saida), .ocupado(ocupado), .pronto(pronto),
    .restante(restante), .erro_code(erro_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int valor;
    logic [5:0] disp;
    int ack_at;
    bit ign;
    int n;
    logic [0:5][7:0] notas;
    int err;
    int rest;
    int hi;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nome, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int step_n, k, nn, gap, first_ev, pr, bad_gap, zero_bad;
    logic prev;
    logic [7:0] got [8];
    disponivel = v.disp;
    valor_troco = 8'(v.valor);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    valor_troco = '0;
    step_n = 1; first_ev = -1; nn = 0; k = 0; gap = 0; pr = 0; bad_gap = 0; zero_bad = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) got[i] = '0;
    while (step_n < 300) begin
      if (first_ev < 0 && (libera || pronto || erro_code != 3'b000)) first_ev = step_n;
      if (!libera && nota_saida != 8'd0) zero_bad++;
      if (libera && !prev) begin
        if (nn > 0 && gap != 2) bad_gap++;
        if (nn < 8) got[nn] = nota_saida;
        nn++;
        k = 0;
        if (v.ign && nn == 2) begin
          iniciar = 1'b1;
          valor_troco = 8'd33;
        end
      end
      if (libera) begin
        k++;
        gap = 0;
      end else gap++;
      if (pronto) pr++;
      if (!libera && !ocupado && (pr > 0 || erro_code != 3'b000)) break;
      nota_ack = libera && (k == v.ack_at);
      prev = libera;
      tick();
      iniciar = 1'b0;
      valor_troco = '0;
      step_n++;
    end
    nota_ack = 1'b0;
    chk($sformatf("c%0d_terminou", idx), int'(step_n < 300), 1);
    chk($sformatf("c%0d_latencia", idx), first_ev, 2);
    chk($sformatf("c%0d_n_notas", idx), nn, v.n);
    for (int i = 0; i < v.n && i < 6; i++)
      chk($sformatf("c%0d_nota%0d", idx, i), int'(got[i]), int'(v.notas[i]));
    chk($sformatf("c%0d_erro", idx), int'(erro_code), v.err);
    chk($sformatf("c%0d_restante", idx), int'(restante), v.rest);
    chk($sformatf("c%0d_pronto", idx), pr, v.err == 0 ? 1 : 0);
    chk($sformatf("c%0d_gap", idx), bad_gap, 0);
    chk($sformatf("c%0d_nota_zero", idx), zero_bad, 0);
    if (v.hi != 0) chk($sformatf("c%0d_libera_ciclos", idx), k, v.hi);
    if (v.err != 0) begin
      chk($sformatf("c%0d_ocupado_erro", idx), int'(ocupado), 0);
      chk($sformatf("c%0d_libera_erro", idx), int'(libera), 0);
      limpar_erro = 1'b1;
      tick();
      limpar_erro = 1'b0;
      chk($sformatf("c%0d_limpo_erro", idx), int'(erro_code), 0);
      chk($sformatf("c%0d_limpo_rest", idx), int'(restante), 0);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; nota_ack = 1'b0; limpar_erro = 1'b0;
    valor_troco = '0; disponivel = '0;
    tbl[0] = '{valor:87, disp:6'h3f, ack_at:1, ign:0, n:5, notas:'{8'd50, 8'd20, 8'd10, 8'd5, 8'd2, 8'd0}, err:0, rest:0, hi:1};
    tbl[1] = '{valor:9, disp:6'h03, ack_at:1, ign:0, n:3, notas:'{8'd5, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0}, err:0, rest:0, hi:0};
    tbl[2] = '{valor:7, disp:6'h02, ack_at:2, ign:0, n:1, notas:'{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err:4, rest:2, hi:0};
    tbl[3] = '{valor:6, disp:6'h03, ack_at:1, ign:0, n:1, notas:'{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err:4, rest:1, hi:0};
    tbl[4] = '{valor:20, disp:6'h3f, ack_at:0, ign:0, n:1, notas:'{8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err:3, rest:20, hi:16};
    tbl[5] = '{valor:20, disp:6'h3f, ack_at:16, ign:0, n:1, notas:'{8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err:0, rest:0, hi:16};
    tbl[6] = '{valor:0, disp:6'h3f, ack_at:1, ign:0, n:0, notas:'{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err:0, rest:0, hi:0};
    tbl[7] = '{valor:1, disp:6'h3f, ack_at:1, ign:0, n:0, notas:'{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err:4, rest:1, hi:0};
    tbl[8] = '{valor:188, disp:6'h3f, ack_at:3, ign:0, n:6, notas:'{8'd100, 8'd50, 8'd20, 8'd10, 8'd5, 8'd2}, err:4, rest:1, hi:0};
    tbl[9] = '{valor:87, disp:6'h3f, ack_at:1, ign:1, n:5, notas:'{8'd50, 8'd20, 8'd10, 8'd5, 8'd2, 8'd0}, err:0, rest:0, hi:0};
    tick();
    tick();
    reset = 1'b0;
    chk("rst_libera", int'(libera), 0);
    chk("rst_nota", int'(nota_saida), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_restante", int'(restante), 0);
    chk("rst_erro", int'(erro_code), 0);
    for (int i = 0; i < 10; i++) run_case(i, tbl[i]);
    disponivel = 6'h3f;
    valor_troco = 8'd87;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    chk("mid_libera", int'(libera), 1);
    chk("mid_nota", int'(nota_saida), 50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_libera", int'(libera), 0);
    chk("mid_rst_nota", int'(nota_saida), 0);
    chk("mid_rst_restante", int'(restante), 0);
    chk("mid_rst_ocupado", int'(ocupado), 0);
    nota_ack = 1'b1;
    tick();
    nota_ack = 1'b0;
    tick();
    chk("ack_ignorado_libera", int'(libera), 0);
    chk("ack_ignorado_ocupado", int'(ocupado), 0);
    chk("ack_ignorado_restante", int'(restante), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
